tod_counter: RTL and testbench
==============================

# tod_counter

Parametrised time-of-day counter: seconds, minutes, hours and day count advanced from the 1 Hz clock, with per-field adjust buttons, a parallel load, a pause enable and runtime 12/24-hour display. It replaces the separate hours-counter arrangement in the digital clock. It feeds the display/BCD stage directly and produces a registered end-of-day pulse for the calendar and alarm logic.

## Interface
- `SEC_MOD`, default 60: seconds modulus (count 0..SEC_MOD-1).
- `MIN_MOD`, default 60: minutes modulus.
- `HRS_MOD`, default 24: hours modulus. 12 h display is valid only when this is 24.
- `DAY_W`, default 9: day counter width; the day counter wraps at 2^DAY_W.
- Field widths are derived: `SW=$clog2(SEC_MOD)`, `MW=$clog2(MIN_MOD)`, `HW=$clog2(HRS_MOD)`.

Ports:
- `sig_1Hz`  in  1: clock. One rising edge is one second.
- `reset`  in  1: synchronous, active-high. Sampled on the `sig_1Hz` rising edge.
- `en`  in  1: count enable. When low, time holds; adjust and load still act.
- `mode_12h`  in  1: display mode. 1 selects 12 h, 0 selects 24 h.
- `sec_b`, `min_b`, `hrs_b`  in  1 each: field adjust, +1 per cycle while high.
- `load`  in  1: parallel load strobe.
- `load_hrs`  in  HW: load value, hours (24 h encoding).
- `load_min`  in  MW: load value, minutes.
- `load_sec`  in  SW: load value, seconds.
- `sec_ctr`  out  SW: seconds.
- `min_ctr`  out  MW: minutes.
- `hrs_ctr`  out  HW: hours, 24 h encoding 0..HRS_MOD-1.
- `disp_hrs`  out  HW: displayed hours.
- `pm`  out  1: PM indicator.
- `day_ctr`  out  DAY_W: completed days.
- `end_day`  out  1: one-cycle pulse on day rollover.
- `load_err`  out  1: one-cycle pulse when a load is rejected.

## Operation
- State: `sec_ctr`, `min_ctr`, `hrs_ctr`, `day_ctr`, `end_day`, `load_err`. All registered.
- Reset values: all registers 0. This gives `disp_hrs`=12 and `pm`=0 in 12 h mode, and `disp_hrs`=0 in 24 h mode.
- Each cycle, priority is: `reset` > `load` > adjust > normal count.
- Load:
  - Applies only when `load_sec`<SEC_MOD, `load_min`<MIN_MOD and `load_hrs`<HRS_MOD.
  - On accept, all three fields take the load values; `day_ctr` is unchanged.
  - Any out-of-range field rejects the whole load: state holds and `load_err` pulses.
- Adjust (no `load`):
  - Each asserted button increments its own field modulo its modulus. There is no carry into the next field.
  - Simultaneous buttons act independently in the same cycle.
  - Normal counting is suppressed in any cycle with an adjust active.
  - `day_ctr` and `end_day` are never affected by adjust.
- Normal count (`en`=1, no load, no adjust):
  - `sec_ctr` increments.
  - At `SEC_MOD-1` it wraps to 0 and carries to minutes. Minutes carry to hours the same way.
  - `end_day` is set for the next cycle exactly when the clock wraps from all-max (`HRS_MOD-1`:`MIN_MOD-1`:`SEC_MOD-1`) to 0:0:0. In that same cycle `day_ctr` increments, wrapping mod 2^DAY_W.
- `end_day` and `load_err` are 0 in every cycle not named above.
- Display (combinational from `hrs_ctr`):
  - 24 h mode, or `HRS_MOD`≠24: `disp_hrs`=`hrs_ctr`, `pm`=0.
  - 12 h mode, `hrs_ctr`=0: `disp_hrs`=12, `pm`=0.
  - 12 h mode, `hrs_ctr`=1..11: `disp_hrs`=`hrs_ctr`, `pm`=0.
  - 12 h mode, `hrs_ctr`=12: `disp_hrs`=12, `pm`=1.
  - 12 h mode, `hrs_ctr`=13..23: `disp_hrs`=`hrs_ctr`-12, `pm`=1.
  - `mode_12h` changes only the display; it never alters stored time.

## Timing
- All state updates occur on the `sig_1Hz` rising edge. Count, adjust and load latency is one cycle.
- Field outputs, `end_day` and `load_err` are registered.
- `disp_hrs` and `pm` follow `hrs_ctr` and `mode_12h` with zero cycles of added latency.
- `reset` mid-operation overrides all other inputs in the same edge. `end_day` is 0 in the cycle after reset, even when reset coincides with 23:59:59.
- `load` coincident with the rollover edge: the load wins, there is no `end_day`, and `day_ctr` holds.
- An adjust held for N cycles gives N increments. There is no edge detection; button debounce/edge detection is upstream.

## Structure
- Package `tod_pkg`: default moduli (60/60/24), `NOON_HR`=12, and a `disp_12h` function.
- Sub-module `mod_counter`:
  - Parameters: `MOD`, `W`.
  - Ports: `inc`, `ld`, `ld_val`, `clr`.
  - Outputs: `q`, and `wrap` (= `inc` && `q`==`MOD`-1).
- Instantiate `mod_counter` three times for sec/min/hrs. The day counter is inline.
- The top level owns the priority muxing, range check, `end_day` and `load_err`.

## Test plan
- Reset, then `en`=1 for 61 cycles → `sec_ctr`=1, `min_ctr`=1, `hrs_ctr`=0, `end_day` never high.
- Load 23:59:58 (accepted), then two count cycles → 23:59:59, then 0:0:0. `end_day`=1 for exactly one cycle; `day_ctr`=1.
- `min_b`=1 at 10:59:30 for one cycle → 10:00:30. Hours unchanged, seconds not advanced.
- `load_hrs`=24 → `load_err` pulse, state unchanged. `load`+`hrs_b`+`en` together with valid values → loaded values only.
- `mode_12h`=1, sweep `hrs_ctr` 0, 11, 12, 13, 23 → `disp_hrs`/`pm` = 12/0, 11/0, 12/1, 1/1, 11/1.
- `reset` asserted at 23:59:59 with `en`=1 → all outputs 0 next cycle, no `end_day`. Also run with `SEC_MOD`=4, `MIN_MOD`=3, `HRS_MOD`=2: full rollover after 24 cycles.

Source files
------------

// File: rtl/tod_pkg.sv
// tod_pkg: shared constants and helpers for the time-of-day counter.
//   SEC_MOD_DEF / MIN_MOD_DEF / HRS_MOD_DEF : default field moduli (60/60/24)
//   NOON_HR                                 : hour value that starts the PM half
//   disp_t / disp_12h                       : 24 h hour -> 12 h display hour + PM flag
package tod_pkg;

    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 60;
    localparam int HRS_MOD_DEF = 24;

    localparam logic [4:0] NOON_HR = 5'd12;

    typedef struct packed {
        logic [4:0] hrs;
        logic       pm;
    } disp_t;

    // Midnight shows as 12 AM and noon as 12 PM; afternoon hours fold down by 12.
    function automatic disp_t disp_12h(input logic [4:0] hrs);
        disp_t d;
        if (hrs == 5'd0) begin
            d.hrs = NOON_HR;
            d.pm  = 1'b0;
        end else if (hrs < NOON_HR) begin
            d.hrs = hrs;
            d.pm  = 1'b0;
        end else if (hrs == NOON_HR) begin
            d.hrs = NOON_HR;
            d.pm  = 1'b1;
        end else begin
            d.hrs = hrs - NOON_HR;
            d.pm  = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/tod_counter_mod_counter.sv
// mod_counter: modulo-MOD up counter with clear, parallel load and increment.
//   clk    : clock
//   clr    : synchronous clear (highest priority)
//   ld     : parallel load of ld_val
//   inc    : +1 modulo MOD
//   q      : registered count 0..MOD-1
//   wrap   : inc asserted while q is at MOD-1 (carry out)
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] q_r;

    // Count register: clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= '0;
        end else if (ld) begin
            q_r <= ld_val;
        end else if (inc) begin
            q_r <= (q_r == MAX) ? '0 : q_r + W'(1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q    = q_r;
    assign wrap = inc && (q_r == MAX);

endmodule

// File: rtl/tod_counter.sv
// tod_counter: seconds/minutes/hours/day time-of-day counter clocked at 1 Hz.
//   sig_1Hz, reset          : clock and synchronous active-high reset
//   en                      : normal counting enable
//   mode_12h                : 1 = 12 h display, 0 = 24 h display
//   sec_b, min_b, hrs_b     : per-field +1 adjust (no carry), level sensitive
//   load, load_hrs/min/sec  : parallel load, rejected whole if any field out of range
//   sec_ctr, min_ctr, hrs_ctr, day_ctr : registered time state (hours in 24 h form)
//   disp_hrs, pm            : combinational display hour and PM flag
//   end_day, load_err       : registered one-cycle pulses
module tod_counter
    import tod_pkg::*;
#(
    parameter  int SEC_MOD = SEC_MOD_DEF,
    parameter  int MIN_MOD = MIN_MOD_DEF,
    parameter  int HRS_MOD = HRS_MOD_DEF,
    parameter  int DAY_W   = 9,
    localparam int SW      = $clog2(SEC_MOD),
    localparam int MW      = $clog2(MIN_MOD),
    localparam int HW      = $clog2(HRS_MOD)
) (
    input  logic             sig_1Hz,
    input  logic             reset,
    input  logic             en,
    input  logic             mode_12h,
    input  logic             sec_b,
    input  logic             min_b,
    input  logic             hrs_b,
    input  logic             load,
    input  logic [HW-1:0]    load_hrs,
    input  logic [MW-1:0]    load_min,
    input  logic [SW-1:0]    load_sec,
    output logic [SW-1:0]    sec_ctr,
    output logic [MW-1:0]    min_ctr,
    output logic [HW-1:0]    hrs_ctr,
    output logic [HW-1:0]    disp_hrs,
    output logic             pm,
    output logic [DAY_W-1:0] day_ctr,
    output logic             end_day,
    output logic             load_err
);

    localparam logic [SW-1:0] SEC_MAX = SW'(SEC_MOD - 1);
    localparam logic [MW-1:0] MIN_MAX = MW'(MIN_MOD - 1);
    localparam logic [HW-1:0] HRS_MAX = HW'(HRS_MOD - 1);

    logic             in_range_s;
    logic             load_ok_s;
    logic             adj_s;
    logic             cnt_s;
    logic             sec_inc_s;
    logic             min_inc_s;
    logic             hrs_inc_s;
    logic             sec_wrap_s;
    logic             min_wrap_s;
    logic             hrs_wrap_s;
    logic             roll_s;
    logic [SW-1:0]    sec_q_s;
    logic [MW-1:0]    min_q_s;
    logic [HW-1:0]    hrs_q_s;
    logic [DAY_W-1:0] day_r;
    logic             end_day_r;
    logic             load_err_r;

    assign in_range_s = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) && (load_hrs <= HRS_MAX);
    assign load_ok_s  = load && in_range_s;
    assign adj_s      = sec_b || min_b || hrs_b;
    assign cnt_s      = en && !load && !adj_s;

    // Any load (even a rejected one) suppresses adjust and counting. During adjust
    // each field follows only its own button so a wrap never carries.
    assign sec_inc_s = load ? 1'b0 : (adj_s ? sec_b : cnt_s);
    assign min_inc_s = load ? 1'b0 : (adj_s ? min_b : sec_wrap_s);
    assign hrs_inc_s = load ? 1'b0 : (adj_s ? hrs_b : min_wrap_s);

    // The hours carry is only reachable through the full seconds/minutes chain in count mode.
    assign roll_s = cnt_s && hrs_wrap_s;

    mod_counter #(.MOD(SEC_MOD), .W(SW)) u_sec (
        .clk    (sig_1Hz),
        .clr    (reset),
        .inc    (sec_inc_s),
        .ld     (load_ok_s),
        .ld_val (load_sec),
        .q      (sec_q_s),
        .wrap   (sec_wrap_s)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MW)) u_min (
        .clk    (sig_1Hz),
        .clr    (reset),
        .inc    (min_inc_s),
        .ld     (load_ok_s),
        .ld_val (load_min),
        .q      (min_q_s),
        .wrap   (min_wrap_s)
    );

    mod_counter #(.MOD(HRS_MOD), .W(HW)) u_hrs (
        .clk    (sig_1Hz),
        .clr    (reset),
        .inc    (hrs_inc_s),
        .ld     (load_ok_s),
        .ld_val (load_hrs),
        .q      (hrs_q_s),
        .wrap   (hrs_wrap_s)
    );

    // Day count plus the end-of-day and load-reject pulses.
    always_ff @(posedge sig_1Hz) begin
        if (reset) begin
            day_r      <= '0;
            end_day_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            end_day_r  <= roll_s;
            load_err_r <= load && !in_range_s;
            day_r      <= roll_s ? day_r + DAY_W'(1) : day_r;
        end
    end

    assign sec_ctr  = sec_q_s;
    assign min_ctr  = min_q_s;
    assign hrs_ctr  = hrs_q_s;
    assign day_ctr  = day_r;
    assign end_day  = end_day_r;
    assign load_err = load_err_r;

    generate
        if (HRS_MOD == 24) begin : g_12h
            disp_t disp_s;
            assign disp_s = disp_12h(hrs_q_s);

            // Display mux: 12 h folding only when selected.
            always_comb begin
                disp_hrs = hrs_q_s;
                pm       = 1'b0;
                if (mode_12h) begin
                    disp_hrs = disp_s.hrs;
                    pm       = disp_s.pm;
                end else begin
                    disp_hrs = hrs_q_s;
                    pm       = 1'b0;
                end
            end
        end else begin : g_24h
            assign disp_hrs = hrs_q_s;
            assign pm       = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_tod_counter.sv
// tb_tod_counter: directed plus randomized check of two tod_counter configurations
// (default 60/60/24 and a small 4/3/2 with a 3-bit day counter) against a
// time-in-seconds reference model.
module tb_tod_counter;

    typedef struct {
        int sec;
        int mi;
        int hrs;
        int day;
        int eod;
        int err;
    } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       m12 = 1'b0;
    logic       sec_btn = 1'b0;
    logic       min_btn = 1'b0;
    logic       hrs_btn = 1'b0;
    logic       ld = 1'b0;
    logic [4:0] lh = 5'd0;
    logic [5:0] lm = 6'd0;
    logic [5:0] ls = 6'd0;

    logic [5:0] b_sec, b_min;
    logic [4:0] b_hrs, b_disp;
    logic       b_pm, b_eod, b_err;
    logic [8:0] b_day;

    logic [1:0] s_sec, s_min;
    logic [0:0] s_hrs, s_disp;
    logic       s_pm, s_eod, s_err;
    logic [2:0] s_day;

    tod_counter u_big (
        .sig_1Hz (clk),      .reset (rst),        .en (en),           .mode_12h (m12),
        .sec_b   (sec_btn),  .min_b (min_btn),    .hrs_b (hrs_btn),   .load (ld),
        .load_hrs(lh),       .load_min (lm),      .load_sec (ls),
        .sec_ctr (b_sec),    .min_ctr (b_min),    .hrs_ctr (b_hrs),   .disp_hrs (b_disp),
        .pm      (b_pm),     .day_ctr (b_day),    .end_day (b_eod),   .load_err (b_err)
    );

    tod_counter #(.SEC_MOD(4), .MIN_MOD(3), .HRS_MOD(2), .DAY_W(3)) u_small (
        .sig_1Hz (clk),      .reset (rst),        .en (en),           .mode_12h (m12),
        .sec_b   (sec_btn),  .min_b (min_btn),    .hrs_b (hrs_btn),   .load (ld),
        .load_hrs(lh[0:0]),  .load_min (lm[1:0]), .load_sec (ls[1:0]),
        .sec_ctr (s_sec),    .min_ctr (s_min),    .hrs_ctr (s_hrs),   .disp_hrs (s_disp),
        .pm      (s_pm),     .day_ctr (s_day),    .end_day (s_eod),   .load_err (s_err)
    );

    int  n_vec = 0;
    int  n_bad = 0;
    st_t mb = '{default: 0};
    st_t ms = '{default: 0};

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: time is a single seconds-of-day number; a count step is +1 modulo a day.
    function automatic st_t step(input st_t s, input int sm, input int mm, input int hm,
                                 input int dw, input bit r, input bit e, input bit l,
                                 input int h, input int mi, input int sc,
                                 input bit sb, input bit mbt, input bit hb);
        st_t n;
        int  t;
        n = s;
        n.eod = 0;
        n.err = 0;
        if (r) begin
            n = '{default: 0};
        end else if (l) begin
            if (sc < sm && mi < mm && h < hm) begin
                n.sec = sc;
                n.mi  = mi;
                n.hrs = h;
            end else begin
                n.err = 1;
            end
        end else if (sb || mbt || hb) begin
            n.sec = (s.sec + int'(sb)) % sm;
            n.mi  = (s.mi + int'(mbt)) % mm;
            n.hrs = (s.hrs + int'(hb)) % hm;
        end else if (e) begin
            t = (s.hrs * mm + s.mi) * sm + s.sec + 1;
            if (t == sm * mm * hm) begin
                t     = 0;
                n.day = (s.day + 1) % (1 << dw);
                n.eod = 1;
            end
            n.hrs = t / (mm * sm);
            n.mi  = (t / sm) % mm;
            n.sec = t % sm;
        end
        return n;
    endfunction

    function automatic int exp_disp(input int h, input bit mode, input int hm);
        if (!mode || hm != 24) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    function automatic int exp_pm(input int h, input bit mode, input int hm);
        return (mode && hm == 24 && h >= 12) ? 1 : 0;
    endfunction

    task automatic check_all();
        chk("big_sec",  int'(b_sec),  mb.sec);
        chk("big_min",  int'(b_min),  mb.mi);
        chk("big_hrs",  int'(b_hrs),  mb.hrs);
        chk("big_day",  int'(b_day),  mb.day);
        chk("big_eod",  int'(b_eod),  mb.eod);
        chk("big_err",  int'(b_err),  mb.err);
        chk("big_disp", int'(b_disp), exp_disp(mb.hrs, m12, 24));
        chk("big_pm",   int'(b_pm),   exp_pm(mb.hrs, m12, 24));
        chk("sml_sec",  int'(s_sec),  ms.sec);
        chk("sml_min",  int'(s_min),  ms.mi);
        chk("sml_hrs",  int'(s_hrs),  ms.hrs);
        chk("sml_day",  int'(s_day),  ms.day);
        chk("sml_eod",  int'(s_eod),  ms.eod);
        chk("sml_err",  int'(s_err),  ms.err);
        chk("sml_disp", int'(s_disp), exp_disp(ms.hrs, m12, 2));
        chk("sml_pm",   int'(s_pm),   exp_pm(ms.hrs, m12, 2));
    endtask

    // Drive one cycle of inputs, advance both models, then check after the edge.
    task automatic cyc(input bit r, input bit e, input bit md, input bit l,
                       input int h, input int mi, input int sc,
                       input bit sb, input bit mbt, input bit hb);
        rst = r; en = e; m12 = md; ld = l;
        sec_btn = sb; min_btn = mbt; hrs_btn = hb;
        lh = 5'(h); lm = 6'(mi); ls = 6'(sc);
        mb = step(mb, 60, 60, 24, 9, r, e, l, int'(lh), int'(lm), int'(ls), sb, mbt, hb);
        ms = step(ms, 4, 3, 2, 3, r, e, l, int'(lh[0]), int'(lm[1:0]), int'(ls[1:0]), sb, mbt, hb);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    int hl[5] = '{0, 11, 12, 13, 23};

    initial begin
        int h, mi, sc;
        bit l;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (61) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        cyc(0, 0, 0, 1, 23, 59, 58, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        cyc(0, 0, 0, 1, 10, 59, 30, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);

        cyc(0, 1, 0, 1, 24, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 5, 6, 7, 0, 0, 1);
        cyc(0, 1, 0, 1, 3, 3, 2, 1, 1, 1);

        foreach (hl[i]) begin
            cyc(0, 0, 1, 1, hl[i], 0, 0, 0, 0, 0);
            cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        cyc(0, 0, 0, 1, 23, 59, 59, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 23, 59, 59, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 2, 3, 0, 0, 0);

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (24) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            l = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0: begin h = $urandom_range(31); mi = $urandom_range(63); sc = $urandom_range(63); end
                1: begin h = 23; mi = 59; sc = $urandom_range(59, 50); end
                default: begin h = $urandom_range(23); mi = $urandom_range(59); sc = $urandom_range(59); end
            endcase
            cyc($urandom_range(99) == 0, $urandom_range(7) != 0, $urandom_range(1) == 1, l,
                h, mi, sc,
                $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
